axi_sram_write_responder: RTL
=============================

// Module: axi_sram_write_responder
// PURPOSE
// - AXI-Lite write-channel responder (subordinate) fronting an external async 16-bit SRAM.
// - Accepts AW and W beats, performs one timed SRAM write cycle, then returns a B response.
// - Sits between AXI write initiators (pattern generators, frame writers) and the SRAM pins.
// PARAMETERS
// - AXI_ADDR_WIDTH  20  word address width; drives sram_addr directly, no byte shift.
// - AXI_DATA_WIDTH  16  data width; strobe width STRB_W = (AXI_DATA_WIDTH+7)/8.
// - WE_CYCLES        2  clocks sram_we_n is held low per write; legal range 1..15.
// PORTS
// - clk          in   1        system clock, all logic on posedge.
// - reset_n      in   1        asynchronous, active-low reset.
// - axi_awaddr   in   AW       write address.
// - axi_awvalid  in   1        / axi_awready out 1: AW handshake.
// - axi_wdata    in   DW       write data.
// - axi_wstrb    in   STRB_W   byte strobes.
// - axi_wvalid   in   1        / axi_wready out 1: W handshake.
// - axi_bresp    out  2        always 2'b00 (OKAY).
// - axi_bvalid   out  1        / axi_bready in 1: B handshake.
// - sram_addr    out  AW       SRAM address.
// - sram_dq_o    out  DW       data toward the SRAM; top level builds the tristate.
// - sram_dq_oe   out  1        1 = drive sram_dq_o onto the pins.
// - sram_be_n    out  STRB_W   active-low byte enables, equal to ~axi_wstrb as captured.
// - sram_we_n, sram_oe_n, sram_ce_n   out  1 each   active-low SRAM controls.
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - awready = wready = bvalid = 0; bresp = 0.
//   - we_n = oe_n = ce_n = 1; be_n all 1; dq_oe = 0.
//   - sram_addr = 0; dq_o = 0; state IDLE; both capture flags clear.
// - All outputs are registered. sram_oe_n stays 1 permanently; this block only writes.
// - IDLE:
//   - awready = ~aw_captured and wready = ~w_captured, registered.
//   - Both ready signals are 1 on the first clock after reset release.
//   - AW handshake: latch the address, set aw_captured, drop awready next cycle.
//   - W handshake: latch data and strobe, set w_captured, drop wready next cycle.
//   - AW and W are independent. They may complete in the same cycle or in either order.
//   - Once both flags are set, move to SETUP. That edge is E0.
//   - If the second handshake completes at E0, outputs change at E0.
// - SETUP, 1 cycle starting at E0:
//   - ce_n = 0, we_n = 1, dq_oe = 1; addr, data and be_n driven from the latches.
// - PULSE, WE_CYCLES cycles from E1 to E(WE_CYCLES):
//   - we_n = 0, counted by a 4-bit down-counter. Addr, data and be_n are held stable.
// - HOLD, 1 cycle starting at E(1+WE_CYCLES):
//   - we_n = 1; ce_n, addr, data and dq_oe are still held.
// - RESP, from E(2+WE_CYCLES):
//   - ce_n = 1, dq_oe = 0, bvalid = 1, bresp = OKAY.
//   - bvalid holds until bready is sampled high. Stalling on bready is unbounded with no side effects.
// - B handshake: bvalid drops, capture flags clear, state returns to IDLE.
//   - awready and wready are 1 on the cycle after the B handshake.
// - While busy (SETUP through RESP), awready and wready stay 0. At most one write is outstanding.
// - wstrb = 0: the full cycle still runs with be_n all 1 (no byte written), and the response is OKAY.
// - Reset mid-write: we_n, ce_n and dq_oe go inactive immediately (async). The partial write is abandoned and no B is issued.
// TESTING
// - Reset, then AW and W together:
//   - addr=0x00005, data=0xF0F0, strb=2'b11 -> ready signals 1 after release.
//   - Handshake at E0; we_n low for exactly 2 cycles (E1,E2); bvalid rises at E4 with bresp=00.
//   - SRAM model holds 0xF0F0 at address 5.
// - W one cycle before AW:
//   - wready drops first, and no SRAM activity occurs until AW is taken.
//   - Write lands at the AW address with the earlier data.
// - strb=2'b01, data=0xABCD to a word preloaded 0x1234 -> be_n=2'b10; memory reads 0x12CD.
// - bready held low 10 cycles -> bvalid stays 1 and awready/wready stay 0; then one bready pulse -> both readies return to 1 on the next cycle.
// - 640 back-to-back writes from an initiator model -> every address is correct, exactly 640 B beats, no lost or duplicated write.
// - reset_n pulsed low during PULSE -> we_n=1, ce_n=1, dq_oe=0 in the same cycle; bvalid never asserts; the next write completes normally.

Source files
------------

// File: rtl/axi_sram_write_responder_if.sv
// AXI-Lite write-channel bundle (AW, W, B) between a write initiator and the SRAM write responder.
// Valid/ready rule on every channel: a beat transfers on a rising clk edge where valid and ready are both 1; the sender holds the payload stable while valid is 1 and ready is 0.
interface axi_sram_write_responder_if #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
);
  localparam int STRB_W = (AXI_DATA_WIDTH + 7) / 8;

  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic                      axi_awvalid;
  logic                      axi_awready;
  logic [AXI_DATA_WIDTH-1:0] axi_wdata;
  logic [STRB_W-1:0]         axi_wstrb;
  logic                      axi_wvalid;
  logic                      axi_wready;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;
  logic                      axi_bready;

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid
  );

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/axi_sram_write_responder.sv
// AXI-Lite write responder: collects one AW and one W beat, runs a timed async-SRAM write
// cycle (setup, WE pulse, hold), then returns an OKAY B response. One write outstanding.
module axi_sram_write_responder #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int WE_CYCLES      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  axi_sram_write_responder_if.slave              axi,
  output logic [AXI_ADDR_WIDTH-1:0]              sram_addr,
  output logic [AXI_DATA_WIDTH-1:0]              sram_dq_o,
  output logic                                   sram_dq_oe,
  output logic [(AXI_DATA_WIDTH+7)/8-1:0]        sram_be_n,
  output logic                                   sram_we_n,
  output logic                                   sram_oe_n,
  output logic                                   sram_ce_n,
  output logic [2:0]                             dbg_state_o
);
  localparam int         STRB_W     = (AXI_DATA_WIDTH + 7) / 8;
  localparam logic [3:0] PULSE_LOAD = 4'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t                    state_q;
  logic                      awready_q, wready_q, bvalid_q;
  logic                      aw_cap_q, w_cap_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_lat_q, sram_addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_lat_q, dq_q;
  logic [STRB_W-1:0]         strb_lat_q, be_n_q;
  logic                      we_n_q, ce_n_q, dq_oe_q;
  logic [3:0]                cnt_q;

  logic                      aw_hs, w_hs, aw_cap_d, w_cap_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_d;
  logic [STRB_W-1:0]         strb_d;

  // A beat arriving on the same edge the pair completes bypasses the latch into the SRAM outputs.
  always_comb begin
    aw_hs    = axi.axi_awvalid & awready_q;
    w_hs     = axi.axi_wvalid & wready_q;
    aw_cap_d = aw_cap_q | aw_hs;
    w_cap_d  = w_cap_q | w_hs;
    addr_d   = aw_hs ? axi.axi_awaddr : addr_lat_q;
    data_d   = w_hs ? axi.axi_wdata : data_lat_q;
    strb_d   = w_hs ? axi.axi_wstrb : strb_lat_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      aw_cap_q    <= 1'b0;
      w_cap_q     <= 1'b0;
      addr_lat_q  <= '0;
      data_lat_q  <= '0;
      strb_lat_q  <= '0;
      sram_addr_q <= '0;
      dq_q        <= '0;
      be_n_q      <= '1;
      we_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          aw_cap_q <= aw_cap_d;
          w_cap_q  <= w_cap_d;
          if (aw_hs) addr_lat_q <= axi.axi_awaddr;
          if (w_hs) begin
            data_lat_q <= axi.axi_wdata;
            strb_lat_q <= axi.axi_wstrb;
          end
          if (aw_cap_d && w_cap_d) begin
            state_q     <= ST_SETUP;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            ce_n_q      <= 1'b0;
            dq_oe_q     <= 1'b1;
            sram_addr_q <= addr_d;
            dq_q        <= data_d;
            be_n_q      <= ~strb_d;
          end else begin
            awready_q <= ~aw_cap_d;
            wready_q  <= ~w_cap_d;
          end
        end
        ST_SETUP: begin
          state_q <= ST_PULSE;
          we_n_q  <= 1'b0;
          cnt_q   <= PULSE_LOAD;
        end
        ST_PULSE: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_HOLD;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          state_q  <= ST_RESP;
          ce_n_q   <= 1'b1;
          dq_oe_q  <= 1'b0;
          bvalid_q <= 1'b1;
        end
        ST_RESP: begin
          if (axi.axi_bready) begin
            state_q   <= ST_IDLE;
            bvalid_q  <= 1'b0;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi.axi_awready = awready_q;
  assign axi.axi_wready  = wready_q;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bresp   = 2'b00;
  assign sram_addr       = sram_addr_q;
  assign sram_dq_o       = dq_q;
  assign sram_dq_oe      = dq_oe_q;
  assign sram_be_n       = be_n_q;
  assign sram_we_n       = we_n_q;
  assign sram_oe_n       = 1'b1;
  assign sram_ce_n       = ce_n_q;
  assign dbg_state_o     = state_q;
endmodule
